// File: rtl/lmsm_sequencer_if.sv
// Data-memory request bus between the LM/SM sequencer (master) and data memory (slave).
// Handshake: mem_req with mem_addr/mem_we/mem_wdata held stable until mem_ack; an ack completes the request in that cycle.
interface lmsm_sequencer_if #(
    parameter int DW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks a register list (R0 excluded) and performs
// one register-file <-> memory transfer per selected register at consecutive addresses.
module lmsm_sequencer #(
    parameter int  DW   = 16,
    parameter int  NREG = 8,
    localparam int IW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_load,
    input  logic [DW-1:0]    base_addr,
    input  logic [NREG-1:0]  reg_list,
    output logic             busy,
    output logic             done,
    output logic [IW-1:0]    rf_ra,
    input  logic [DW-1:0]    rf_rd,
    output logic             rf_we,
    output logic [IW-1:0]    rf_wa,
    output logic [DW-1:0]    rf_wd,
    lmsm_sequencer_if.master mem,
    output logic [DW-1:0]    next_addr,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [NREG-1:0] list_q;
    logic            is_load_q;
    logic [DW-1:0]   cur_addr;
    logic            req_q;
    logic            we_q;
    logic [DW-1:0]   addr_q;

    logic [NREG-1:0] start_list;
    logic [NREG-1:0] list_next;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   addr_next;
    logic            advance;

    function automatic logic [IW-1:0] lowest(input logic [NREG-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    // advance = one transfer retired: SM on its ack, LM on its writeback cycle
    always_comb begin
        start_list = reg_list & ~NREG'(1);
        idx        = lowest(list_q);
        list_next  = list_q & ~(NREG'(1) << idx);
        addr_next  = cur_addr + DW'(1);
        advance    = (state == WB) || ((state == ISSUE) && mem.mem_ack && !is_load_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            list_q    <= '0;
            is_load_q <= 1'b0;
            cur_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_ra     <= '0;
            rf_we     <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            next_addr <= '0;
        end else begin
            done  <= 1'b0;
            rf_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        list_q    <= start_list;
                        cur_addr  <= base_addr;
                        is_load_q <= is_load;
                        busy      <= 1'b1;
                        if (start_list == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            next_addr <= base_addr;
                        end else begin
                            state  <= ISSUE;
                            req_q  <= 1'b1;
                            we_q   <= ~is_load;
                            addr_q <= base_addr;
                            rf_ra  <= lowest(start_list);
                        end
                    end
                end

                ISSUE: begin
                    // load data is captured straight into the writeback data register
                    if (mem.mem_ack && is_load_q) begin
                        state <= WB;
                        req_q <= 1'b0;
                        rf_we <= 1'b1;
                        rf_wa <= idx;
                        rf_wd <= mem.mem_rdata;
                    end
                end

                WB: ;

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase

            if (advance) begin
                list_q   <= list_next;
                cur_addr <= addr_next;
                if (list_next == '0) begin
                    state     <= DONE;
                    req_q     <= 1'b0;
                    done      <= 1'b1;
                    next_addr <= addr_next;
                end else begin
                    state  <= ISSUE;
                    req_q  <= 1'b1;
                    we_q   <= ~is_load_q;
                    addr_q <= addr_next;
                    rf_ra  <= lowest(list_next);
                end
            end
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = rf_rd;
    assign fsm_state     = state;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: table of LM/SM sequences against a register-file/memory model,
// with an expected-transfer queue, plus hand-written reset-during-writeback sequence.
module tb_lmsm_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic [15:0] base_addr;
    logic [7:0]  reg_list;
    logic        busy;
    logic        done;
    logic [2:0]  rf_ra;
    logic [15:0] rf_rd;
    logic        rf_we;
    logic [2:0]  rf_wa;
    logic [15:0] rf_wd;
    logic [15:0] next_addr;
    logic [1:0]  fsm_state;

    lmsm_sequencer_if #(.DW(16)) mem_bus ();

    lmsm_sequencer #(.DW(16), .NREG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_load   (is_load),
        .base_addr (base_addr),
        .reg_list  (reg_list),
        .busy      (busy),
        .done      (done),
        .rf_ra     (rf_ra),
        .rf_rd     (rf_rd),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .mem       (mem_bus.master),
        .next_addr (next_addr),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // models and scoreboard state
    logic [15:0] rf_mem [8];
    logic [15:0] mem_arr [65536];
    logic [32:0] mem_exp_q [$];
    logic [18:0] rf_exp_q [$];

    int          total = 0;
    int          bad = 0;
    int          xfer_cnt;
    int          busy_cnt;
    int          done_cnt;
    int          wait_cnt;
    int          ack_delay;
    logic        stray_ack;
    logic [15:0] exp_next;
    logic [32:0] hold_req;

    assign rf_rd = rf_mem[rf_ra];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory responder + monitor: ack decided here holds through the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_bus.mem_ack = 1'b0;
            wait_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                check("next_addr at done", 40'(next_addr), 40'(exp_next));
            end
            if (rf_we) begin
                if (rf_exp_q.size() == 0) begin
                    check("unexpected rf_we", 40'({rf_wa, rf_wd}), 40'h0);
                end else begin
                    check("rf write", 40'({rf_wa, rf_wd}), 40'(rf_exp_q.pop_front()));
                end
                rf_mem[rf_wa] = rf_wd;
            end
            if (mem_bus.mem_req) begin
                if (wait_cnt == 0) begin
                    hold_req = {mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata};
                end else begin
                    check("request stable", 40'({mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}),
                          40'(hold_req));
                end
                if (wait_cnt >= ack_delay) begin
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];
                    xfer_cnt++;
                    if (mem_exp_q.size() == 0) begin
                        check("unexpected mem transfer", 40'({mem_bus.mem_we, mem_bus.mem_addr}), 40'h0);
                    end else begin
                        check("mem transfer",
                              40'({mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_we ? mem_bus.mem_wdata : 16'h0}),
                              40'(mem_exp_q.pop_front()));
                    end
                    if (mem_bus.mem_we) mem_arr[mem_bus.mem_addr] = mem_bus.mem_wdata;
                    wait_cnt = 0;
                end else begin
                    mem_bus.mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_bus.mem_ack   = stray_ack;
                mem_bus.mem_rdata = 16'($urandom);
                wait_cnt = 0;
            end
        end
    end

    typedef struct {
        logic        ld;
        logic [15:0] base;
        logic [7:0]  list;
        int          delay;
        logic        stray;
        logic        mid_start;
        int          exp_xfers;
        logic [15:0] exp_next;
        int          exp_busy;
    } vec_t;

    vec_t vecs [10];

    // expected transfers pushed at launch from the register-file / memory model
    task automatic push_expected(input logic ld, input logic [15:0] base, input logic [7:0] list);
        logic [15:0] a;
        a = base;
        for (int i = 1; i < 8; i++) begin
            if (list[i]) begin
                if (ld) begin
                    mem_exp_q.push_back({1'b0, a, 16'h0});
                    rf_exp_q.push_back({3'(i), mem_arr[a]});
                end else begin
                    mem_exp_q.push_back({1'b1, a, rf_mem[i]});
                end
                a = a + 16'd1;
            end
        end
    endtask

    task automatic run_seq(input vec_t v);
        int guard;
        push_expected(v.ld, v.base, v.list);
        ack_delay = v.delay;
        stray_ack = v.stray;
        xfer_cnt  = 0;
        busy_cnt  = 0;
        done_cnt  = 0;
        exp_next  = v.exp_next;
        @(posedge clk); #1;
        start = 1'b1; is_load = v.ld; base_addr = v.base; reg_list = v.list;
        @(posedge clk); #1;
        start = 1'b0; is_load = 1'($urandom); base_addr = 16'($urandom); reg_list = 8'($urandom);
        guard = 0;
        while (done_cnt == 0 && guard < 400) begin
            if (v.mid_start && guard == 4) begin
                start = 1'b1; is_load = ~v.ld; reg_list = 8'hFF; base_addr = 16'hAAAA;
            end
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        check("done within budget", 40'(guard < 400), 40'd1);
        @(posedge clk); #1;
        check("done count", 40'(done_cnt), 40'd1);
        check("transfer count", 40'(xfer_cnt), 40'(v.exp_xfers));
        check("busy cycles", 40'(busy_cnt), 40'(v.exp_busy));
        check("busy low after done", 40'(busy), 40'd0);
        check("next_addr held", 40'(next_addr), 40'(v.exp_next));
        check("mem queue drained", 40'(mem_exp_q.size()), 40'd0);
        check("rf queue drained", 40'(rf_exp_q.size()), 40'd0);
        mem_exp_q.delete();
        rf_exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 40'(busy), 40'd0);
        check({tag, " done"}, 40'(done), 40'd0);
        check({tag, " rf_we"}, 40'(rf_we), 40'd0);
        check({tag, " mem_req"}, 40'(mem_bus.mem_req), 40'd0);
        check({tag, " mem_we"}, 40'(mem_bus.mem_we), 40'd0);
        check({tag, " rf_ra/rf_wa"}, 40'({rf_ra, rf_wa}), 40'd0);
        check({tag, " rf_wd"}, 40'(rf_wd), 40'd0);
        check({tag, " mem_addr"}, 40'(mem_bus.mem_addr), 40'd0);
        check({tag, " next_addr"}, 40'(next_addr), 40'd0);
        check({tag, " state idle"}, 40'(fsm_state), 40'd0);
    endtask

    initial begin
        int          guard;
        logic [15:0] saved_r1;
        vec_t        post;

        //        ld    base      list   dly str  mid  xfers next      busy
        vecs[0] = '{1'b0, 16'h0100, 8'h16, 0, 1'b0, 1'b0, 3, 16'h0103, 4};
        vecs[1] = '{1'b1, 16'h0040, 8'h81, 0, 1'b0, 1'b0, 1, 16'h0041, 3};
        vecs[2] = '{1'b0, 16'h1234, 8'h01, 0, 1'b0, 1'b0, 0, 16'h1234, 1};
        vecs[3] = '{1'b1, 16'h5555, 8'h00, 0, 1'b0, 1'b0, 0, 16'h5555, 1};
        vecs[4] = '{1'b1, 16'hFFFF, 8'h0C, 0, 1'b0, 1'b0, 2, 16'h0001, 5};
        vecs[5] = '{1'b0, 16'h0200, 8'hFE, 3, 1'b0, 1'b1, 7, 16'h0207, 29};
        vecs[6] = '{1'b1, 16'h0300, 8'hAA, 1, 1'b1, 1'b0, 4, 16'h0304, 13};
        vecs[7] = '{1'b0, 16'hFFFE, 8'hFF, 0, 1'b0, 1'b0, 7, 16'h0005, 8};
        vecs[8] = '{1'b1, 16'h0010, 8'hFF, 0, 1'b0, 1'b0, 7, 16'h0017, 15};
        vecs[9] = '{1'b0, 16'h0000, 8'h80, 2, 1'b0, 1'b0, 1, 16'h0001, 4};

        for (int i = 0; i < 65536; i++) mem_arr[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) rf_mem[i] = 16'($urandom);
        rf_mem[1] = 16'h0001;
        rf_mem[2] = 16'h0002;
        rf_mem[4] = 16'hFFFF;
        mem_arr[16'h0040] = 16'hBEEF;

        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; base_addr = '0; reg_list = '0;
        ack_delay = 0; stray_ack = 1'b0; wait_cnt = 0;
        xfer_cnt = 0; busy_cnt = 0; done_cnt = 0; exp_next = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_seq(vecs[i]);

        // reset asserted while the first LM writeback is on rf_we
        ack_delay = 0; stray_ack = 1'b0; saved_r1 = rf_mem[1];
        push_expected(1'b1, 16'h0500, 8'h02);
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b1; base_addr = 16'h0500; reg_list = 8'h06;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (rf_we !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rf_we reached before reset", 40'(rf_we), 40'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset in WB");
        repeat (2) @(posedge clk);
        #1;
        check("abandoned write not committed", 40'(rf_mem[1]), 40'(saved_r1));
        check("abandoned rf write left pending", 40'(rf_exp_q.size()), 40'd1);
        mem_exp_q.delete();
        rf_exp_q.delete();
        rst_n = 1'b1;

        post = '{1'b1, 16'h0700, 8'h06, 0, 1'b0, 1'b0, 2, 16'h0702, 5};
        run_seq(post);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
